fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter_if.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 130 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between two byte requesters, the arbiter and a FIFO.
// Latency: n/a (wires only).
// Backpressure: fifo_full on this bundle stalls the granted requester via reqN_ready.
//
// Modports:
//   master - requesters/FIFO side: drives valids, data and fifo_full
//   slave  - arbiter side: drives readies, FIFO strobe/data, grant, counters
interface fifo_wr_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       fifo_full;
    logic       fifo_wr_en;
    logic [7:0] fifo_data;
    logic [1:0] grant;
    logic [7:0] wr_cnt0;
    logic [7:0] wr_cnt1;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, fifo_full,
        input  req0_ready, req1_ready, fifo_wr_en, fifo_data, grant,
               wr_cnt0, wr_cnt1
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, fifo_full,
        output req0_ready, req1_ready, fifo_wr_en, fifo_data, grant,
               wr_cnt0, wr_cnt1
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Two-requester round-robin burst arbiter feeding one FIFO write port.
// Latency: grant 1 cycle after valid is seen in IDLE, then one byte per cycle.
// Backpressure: fifo_full stalls the transfer and freezes grant and beat count.
//
// Ports:
//   clk  - single clock, all state on rising edge
//   rst  - asynchronous active-low reset
//   bus  - fifo_wr_arbiter_if.slave: req0/req1 valid/data/ready, fifo_full,
//          fifo_wr_en, fifo_data, grant (one-hot owner), wr_cnt0/wr_cnt1
// Optional feature: define FIFO_ARB_STATS_EN for saturating per-requester
// write counters; otherwise wr_cnt0/wr_cnt1 read as 8'h00.
module fifo_wr_arbiter #(
    parameter int unsigned BURST_LEN = 4   // 1..15 consecutive writes per grant
) (
    input logic            clk,
    input logic            rst,
    fifo_wr_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [3:0] BEAT_LAST = 4'(BURST_LEN - 1);

    state_t     state;
    logic [3:0] beat_cnt;
    logic       last_grant;   // requester that most recently entered a grant
    logic       xfer0;
    logic       xfer1;

    // Because reset clears state asynchronously, every output decoded from
    // state drops the moment rst falls, even mid-burst.
    assign xfer0 = (state == GRANT0) && bus.req0_valid && !bus.fifo_full;
    assign xfer1 = (state == GRANT1) && bus.req1_valid && !bus.fifo_full;

    assign bus.req0_ready = xfer0;
    assign bus.req1_ready = xfer1;
    assign bus.fifo_wr_en = xfer0 | xfer1;
    assign bus.grant      = {state == GRANT1, state == GRANT0};

    always_comb begin
        bus.fifo_data = 8'h00;
        case (state)
            GRANT0:  bus.fifo_data = bus.req0_data;
            GRANT1:  bus.fifo_data = bus.req1_data;
            default: bus.fifo_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            beat_cnt   <= 4'd0;
            last_grant <= 1'b1;   // so requester 0 wins the first tie
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt <= 4'd0;
                    if (bus.req0_valid && (!bus.req1_valid || last_grant)) begin
                        state      <= GRANT0;
                        last_grant <= 1'b0;
                    end else if (bus.req1_valid) begin
                        state      <= GRANT1;
                        last_grant <= 1'b1;
                    end
                end
                GRANT0: begin
                    // A full FIFO freezes everything, including burst-limit handover.
                    if (!bus.fifo_full) begin
                        if (!bus.req0_valid || beat_cnt == BEAT_LAST) begin
                            beat_cnt <= 4'd0;
                            if (bus.req1_valid) begin
                                state      <= GRANT1;
                                last_grant <= 1'b1;
                            end else if (!bus.req0_valid) begin
                                state <= IDLE;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 4'd1;
                        end
                    end
                end
                GRANT1: begin
                    if (!bus.fifo_full) begin
                        if (!bus.req1_valid || beat_cnt == BEAT_LAST) begin
                            beat_cnt <= 4'd0;
                            if (bus.req0_valid) begin
                                state      <= GRANT0;
                                last_grant <= 1'b0;
                            end else if (!bus.req1_valid) begin
                                state <= IDLE;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat_cnt <= 4'd0;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt0 <= 8'h00;
            cnt1 <= 8'h00;
        end else begin
            if (xfer0 && cnt0 != 8'hFF) cnt0 <= cnt0 + 8'd1;
            if (xfer1 && cnt1 != 8'hFF) cnt1 <= cnt1 + 8'd1;
        end
    end

    assign bus.wr_cnt0 = cnt0;
    assign bus.wr_cnt1 = cnt1;
`else
    assign bus.wr_cnt0 = 8'h00;
    assign bus.wr_cnt1 = 8'h00;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with BURST_LEN=4.
// Latency: inputs change just after the falling edge, outputs checked 1 time unit later.
// Backpressure: fifo_full is driven directly to exercise stalls.
module tb_fifo_wr_arbiter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    fifo_wr_arbiter_if bus ();

    fifo_wr_arbiter #(.BURST_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FIFO_ARB_STATS_EN
    localparam logic [7:0] SAT_EXP = 8'hFF;
`else
    localparam logic [7:0] SAT_EXP = 8'h00;
`endif

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [1:0] g, input logic we,
                              input logic [7:0] d, input logic r0, input logic r1);
        chk({tag, ".grant"}, {6'd0, bus.grant}, {6'd0, g});
        chk({tag, ".wr_en"}, {7'd0, bus.fifo_wr_en}, {7'd0, we});
        chk({tag, ".data"},  bus.fifo_data, d);
        chk({tag, ".rdy0"},  {7'd0, bus.req0_ready}, {7'd0, r0});
        chk({tag, ".rdy1"},  {7'd0, bus.req1_ready}, {7'd0, r1});
    endtask

    // Advance to the next falling edge; caller then drives inputs and waits #1.
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] d0;
        logic [7:0] d1;
        logic       own1;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_data  = 8'h00;
        bus.req1_valid = 1'b0;
        bus.req1_data  = 8'h00;
        bus.fifo_full  = 1'b0;

        // Reset state
        cyc(); cyc();
        bus.req0_data = 8'h5A;
        #1;
        expect_out("reset", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("reset.cnt0", bus.wr_cnt0, 8'h00);
        chk("reset.cnt1", bus.wr_cnt1, 8'h00);

        // Both requesters continuously valid: 4 x req0, 4 x req1, 4 x req0
        cyc();
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        expect_out("rr.idle", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            cyc();
            d0 = 8'hA0 + 8'(i);
            d1 = 8'hB0 + 8'(i);
            bus.req0_data = d0;
            bus.req1_data = d1;
            own1 = ((i / 4) % 2) == 1;
            #1;
            expect_out($sformatf("rr.beat%0d", i), own1 ? 2'b10 : 2'b01, 1'b1,
                       own1 ? d1 : d0, !own1, own1);
        end
        cyc();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        expect_out("rr.drop", 2'b10, 1'b0, 8'hB0 + 8'd11, 1'b0, 1'b0);
        cyc(); #1;
        expect_out("rr.idle2", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);

        // Full stall after req0's second beat; req1 waiting takes over after beat 4
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_data  = 8'h20;
        bus.req1_data  = 8'h30;
        #1;
        expect_out("full.idle", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(); #1;
        expect_out("full.b1", 2'b01, 1'b1, 8'h20, 1'b1, 1'b0);
        cyc(); bus.req0_data = 8'h21; #1;
        expect_out("full.b2", 2'b01, 1'b1, 8'h21, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            bus.req0_data = 8'h22;
            bus.fifo_full = 1'b1;
            #1;
            expect_out($sformatf("full.stall%0d", i), 2'b01, 1'b0, 8'h22, 1'b0, 1'b0);
        end
        cyc(); bus.fifo_full = 1'b0; #1;
        expect_out("full.b3", 2'b01, 1'b1, 8'h22, 1'b1, 1'b0);
        cyc(); bus.req0_data = 8'h23; #1;
        expect_out("full.b4", 2'b01, 1'b1, 8'h23, 1'b1, 1'b0);
        cyc(); #1;
        expect_out("full.handover", 2'b10, 1'b1, 8'h30, 1'b0, 1'b1);
        cyc();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        expect_out("full.drop", 2'b10, 1'b0, 8'h30, 1'b0, 1'b0);
        cyc(); #1;
        expect_out("full.idle2", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);

        // req0 drops valid after 2 beats while req1 waits
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_data  = 8'h40;
        bus.req1_data  = 8'h50;
        cyc(); #1;
        expect_out("drop.b1", 2'b01, 1'b1, 8'h40, 1'b1, 1'b0);
        cyc(); bus.req0_data = 8'h41; #1;
        expect_out("drop.b2", 2'b01, 1'b1, 8'h41, 1'b1, 1'b0);
        cyc(); bus.req0_valid = 1'b0; #1;
        expect_out("drop.gap", 2'b01, 1'b0, 8'h41, 1'b0, 1'b0);
        cyc(); #1;
        expect_out("drop.g1", 2'b10, 1'b1, 8'h50, 1'b0, 1'b1);

        // Reset mid-burst: outputs fall immediately; req0 wins first tie after release
        bus.req0_valid = 1'b1;
        cyc(); bus.req1_data = 8'h51; #1;
        expect_out("mid.pre", 2'b10, 1'b1, 8'h51, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        expect_out("mid.rst", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("mid.cnt0", bus.wr_cnt0, 8'h00);
        chk("mid.cnt1", bus.wr_cnt1, 8'h00);
        cyc(); cyc();
        rst = 1'b1;
        bus.req0_data = 8'h60;
        #1;
        expect_out("mid.idle", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(); #1;
        expect_out("mid.first", 2'b01, 1'b1, 8'h60, 1'b1, 1'b0);
        cyc();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        expect_out("mid.drop", 2'b01, 1'b0, 8'h60, 1'b0, 1'b0);

        // req0 alone, 6 bytes 0x10..0x15, no bubble at the burst boundary
        cyc();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h10;
        #1;
        expect_out("solo.idle", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            d0 = 8'h10 + 8'(i);
            bus.req0_data = d0;
            #1;
            expect_out($sformatf("solo.b%0d", i), 2'b01, 1'b1, d0, 1'b1, 1'b0);
        end
        cyc(); bus.req0_valid = 1'b0; #1;
        expect_out("solo.drop", 2'b01, 1'b0, 8'h15, 1'b0, 1'b0);
        cyc(); #1;
        expect_out("solo.idle2", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);

        // req0 was served last, so the next tie goes to req1
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h70;
        cyc(); #1;
        expect_out("tie.r1", 2'b10, 1'b1, 8'h70, 1'b0, 1'b1);

        // 300 req0 writes from fresh reset: counter saturates when enabled
        cyc();
        rst = 1'b0;
        bus.req1_valid = 1'b0;
        cyc();
        rst = 1'b1;
        repeat (301) cyc();
        bus.req0_valid = 1'b0;
        cyc(); #1;
        chk("stats.cnt0", bus.wr_cnt0, SAT_EXP);
        chk("stats.cnt1", bus.wr_cnt1, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
